// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory
// access and write-back. It drives datapath strobes, guards memory waits
// with a timeout, counts retired instructions and traps on illegal opcodes
// or bus timeouts.
//
// Memory handshake: mem_req is held high for every cycle spent in FETCH or
// MEM. The memory completes by pulsing mem_ack for exactly one cycle. The
// request is accepted on the cycle where mem_req and mem_ack are both high,
// and the FSM leaves the wait state on the following edge. mem_ack seen in
// any other state is ignored.
module rv_multicycle_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        branch_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [6:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] wait_cnt;
  logic [1:0]  cause_q;
  logic [1:0]  cause_d;
  logic [31:0] instret_q;
  logic        retire;
  logic        timed_out;
  logic        legal_op;

  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

  // A wait expires when the cycle just counted was the TIMEOUT-th without ack.
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));

  // Opcode legality is judged on the live decoder output during DECODE.
  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: legal_op = 1'b1;
      default:                          legal_op = 1'b0;
    endcase
  end

  // Next-state, strobe and retire decode for the current state.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (legal_op) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (op_q == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? 2'b01 : 2'b00;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_STORE);
        if (mem_ack) begin
          if (op_q == OP_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = 2'b00;
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        rf_we = (rd_q != 5'd0);
        case (op_q)
          OP_LUI:           wb_sel = 2'b11;
          OP_LOAD:          wb_sel = 2'b01;
          OP_JAL, OP_JALR:  wb_sel = 2'b10;
          default:          wb_sel = 2'b00;
        endcase
        pc_we = 1'b1;
        case (op_q)
          OP_JAL:  pc_sel = 2'b01;
          OP_JALR: pc_sel = 2'b10;
          default: pc_sel = 2'b00;
        endcase
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        // Encoding 6 is never entered legitimately; treat it as corruption.
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  // State, trap cause and retired-instruction counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      cause_q   <= 2'b00;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  // Wait counter: restarts on every state change, counts ack-less wait cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 32'd0;
    end else if (state_d != state_q) begin
      wait_cnt <= 32'd0;
    end else if (state_q == S_FETCH || state_q == S_MEM) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  // Capture the decoded instruction fields while in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 7'd0;
      rd_q <= 5'd0;
    end else if (state_q == S_DECODE) begin
      op_q <= opcode;
      rd_q <= rd;
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: a driver applies one input vector per cycle
// and queues the hand-computed output vector for that cycle; a monitor pops
// and compares on each falling edge.
module tb_rv_multicycle_ctrl;

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // Strobe vector: {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel[1:0], rf_we, wb_sel[1:0]}
  localparam logic [9:0] NONE     = 10'b0000000000;
  localparam logic [9:0] F_REQ    = 10'b1000000000;
  localparam logic [9:0] F_ACK    = 10'b1001000000;
  localparam logic [9:0] M_LD     = 10'b1010000000;
  localparam logic [9:0] M_ST     = 10'b1110000000;
  localparam logic [9:0] M_ST_ACK = 10'b1110100000;
  localparam logic [9:0] WB_ADDI  = 10'b0000100100;
  localparam logic [9:0] WB_LOAD  = 10'b0000100101;
  localparam logic [9:0] WB_JAL0  = 10'b0000101010;
  localparam logic [9:0] WB_JALR1 = 10'b0000110110;
  localparam logic [9:0] WB_LUI   = 10'b0000100111;
  localparam logic [9:0] EX_BT    = 10'b0000101000;
  localparam logic [9:0] EX_BN    = 10'b0000100000;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        branch_taken;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  logic [47:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          errors;
  logic [47:0] mon_exp;
  logic [47:0] mon_act;
  string       mon_name;

  rv_multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .rd           (rd),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .state        (state),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .instret      (instret)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one cycle of inputs plus the expected outputs for that cycle
  task automatic step(input string nm, input logic rstv, input logic ackv,
                      input logic btv, input logic [6:0] opv, input logic [4:0] rdv,
                      input logic [2:0] est, input logic [9:0] estr,
                      input logic [1:0] ecause, input logic [31:0] einst);
    @(posedge clk);
    #1;
    rst_n        = rstv;
    mem_ack      = ackv;
    branch_taken = btv;
    opcode       = opv;
    rd           = rdv;
    exp_q.push_back({est, estr, (est == S_TRAP), ecause, einst});
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                  rf_we, wb_sel, trap, trap_cause, instret};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: actual=%h required=%h", mon_name, mon_act, mon_exp);
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    opcode       = 7'd0;
    rd           = 5'd0;
    branch_taken = 1'b0;
    mem_ack      = 1'b0;

    // Reset state
    step("reset0",   0, 0, 0, OP_IMM, 5, S_BOOT,   NONE,    2'b00, 0);
    step("reset1",   0, 0, 0, OP_IMM, 5, S_BOOT,   NONE,    2'b00, 0);
    step("boot",     1, 0, 0, OP_IMM, 5, S_BOOT,   NONE,    2'b00, 0);
    // ADDI rd=5, ack on first fetch cycle
    step("addi_f",   1, 1, 0, OP_IMM, 5, S_FETCH,  F_ACK,   2'b00, 0);
    step("addi_d",   1, 0, 0, OP_IMM, 5, S_DECODE, NONE,    2'b00, 0);
    step("addi_e",   1, 0, 0, OP_IMM, 5, S_EXEC,   NONE,    2'b00, 0);
    step("addi_wb",  1, 0, 0, OP_IMM, 5, S_WB,     WB_ADDI, 2'b00, 0);
    // LOAD rd=3, data ack three cycles late
    step("ld_f",     1, 1, 0, OP_LOAD, 3, S_FETCH,  F_ACK,   2'b00, 1);
    step("ld_d",     1, 0, 0, OP_LOAD, 3, S_DECODE, NONE,    2'b00, 1);
    step("ld_e",     1, 0, 0, OP_LOAD, 3, S_EXEC,   NONE,    2'b00, 1);
    step("ld_m0",    1, 0, 0, OP_LOAD, 3, S_MEM,    M_LD,    2'b00, 1);
    step("ld_m1",    1, 0, 0, OP_LOAD, 3, S_MEM,    M_LD,    2'b00, 1);
    step("ld_m2",    1, 0, 0, OP_LOAD, 3, S_MEM,    M_LD,    2'b00, 1);
    step("ld_m3",    1, 1, 0, OP_LOAD, 3, S_MEM,    M_LD,    2'b00, 1);
    step("ld_wb",    1, 0, 0, OP_LOAD, 3, S_WB,     WB_LOAD, 2'b00, 1);
    // BRANCH taken, then not taken
    step("bt_f",     1, 1, 0, OP_BRANCH, 0, S_FETCH,  F_ACK, 2'b00, 2);
    step("bt_d",     1, 0, 0, OP_BRANCH, 0, S_DECODE, NONE,  2'b00, 2);
    step("bt_e",     1, 0, 1, OP_BRANCH, 0, S_EXEC,   EX_BT, 2'b00, 2);
    step("bn_f",     1, 1, 0, OP_BRANCH, 0, S_FETCH,  F_ACK, 2'b00, 3);
    step("bn_d",     1, 0, 0, OP_BRANCH, 0, S_DECODE, NONE,  2'b00, 3);
    step("bn_e",     1, 0, 0, OP_BRANCH, 0, S_EXEC,   EX_BN, 2'b00, 3);
    // JAL rd=0 (stray ack in DECODE must be ignored)
    step("jal_f",    1, 1, 0, OP_JAL, 0, S_FETCH,  F_ACK,   2'b00, 4);
    step("jal_d",    1, 1, 0, OP_JAL, 0, S_DECODE, NONE,    2'b00, 4);
    step("jal_e",    1, 0, 0, OP_JAL, 0, S_EXEC,   NONE,    2'b00, 4);
    step("jal_wb",   1, 0, 0, OP_JAL, 0, S_WB,     WB_JAL0, 2'b00, 4);
    // JALR rd=1
    step("jalr_f",   1, 1, 0, OP_JALR, 1, S_FETCH,  F_ACK,    2'b00, 5);
    step("jalr_d",   1, 0, 0, OP_JALR, 1, S_DECODE, NONE,     2'b00, 5);
    step("jalr_e",   1, 0, 0, OP_JALR, 1, S_EXEC,   NONE,     2'b00, 5);
    step("jalr_wb",  1, 0, 0, OP_JALR, 1, S_WB,     WB_JALR1, 2'b00, 5);
    // STORE completing normally
    step("st_f",     1, 1, 0, OP_STORE, 2, S_FETCH,  F_ACK,    2'b00, 6);
    step("st_d",     1, 0, 0, OP_STORE, 2, S_DECODE, NONE,     2'b00, 6);
    step("st_e",     1, 0, 0, OP_STORE, 2, S_EXEC,   NONE,     2'b00, 6);
    step("st_m",     1, 1, 0, OP_STORE, 2, S_MEM,    M_ST_ACK, 2'b00, 6);
    // STORE with fetch ack on the 4th (last allowed) cycle, reset mid-MEM
    step("st2_f0",   1, 0, 0, OP_STORE, 2, S_FETCH,  F_REQ, 2'b00, 7);
    step("st2_f1",   1, 0, 0, OP_STORE, 2, S_FETCH,  F_REQ, 2'b00, 7);
    step("st2_f2",   1, 0, 0, OP_STORE, 2, S_FETCH,  F_REQ, 2'b00, 7);
    step("st2_f3",   1, 1, 0, OP_STORE, 2, S_FETCH,  F_ACK, 2'b00, 7);
    step("st2_d",    1, 0, 0, OP_STORE, 2, S_DECODE, NONE,  2'b00, 7);
    step("st2_e",    1, 0, 0, OP_STORE, 2, S_EXEC,   NONE,  2'b00, 7);
    step("st2_m0",   1, 0, 0, OP_STORE, 2, S_MEM,    M_ST,  2'b00, 7);
    step("st2_m1",   1, 0, 0, OP_STORE, 2, S_MEM,    M_ST,  2'b00, 7);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, mem_req, mem_we, instret} !== {S_BOOT, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL rst_async: actual st=%0d req=%b we=%b inst=%0d required st=0 req=0 we=0 inst=0",
               state, mem_req, mem_we, instret);
    end
    step("rst_hold", 0, 0, 0, OP_LUI, 7, S_BOOT, NONE, 2'b00, 0);
    step("boot2",    1, 0, 0, OP_LUI, 7, S_BOOT, NONE, 2'b00, 0);
    // LUI rd=7, then illegal opcode trap
    step("lui_f",    1, 1, 0, OP_LUI, 7, S_FETCH,  F_ACK,  2'b00, 0);
    step("lui_d",    1, 0, 0, OP_LUI, 7, S_DECODE, NONE,   2'b00, 0);
    step("lui_e",    1, 0, 0, OP_LUI, 7, S_EXEC,   NONE,   2'b00, 0);
    step("lui_wb",   1, 0, 0, OP_LUI, 7, S_WB,     WB_LUI, 2'b00, 0);
    step("bad_f",    1, 1, 0, OP_BAD, 4, S_FETCH,  F_ACK,  2'b00, 1);
    step("bad_d",    1, 0, 0, OP_BAD, 4, S_DECODE, NONE,   2'b00, 1);
    step("bad_t0",   1, 1, 0, OP_BAD, 4, S_TRAP,   NONE,   2'b01, 1);
    step("bad_t1",   1, 0, 0, OP_BAD, 4, S_TRAP,   NONE,   2'b01, 1);
    step("bad_t2",   1, 1, 0, OP_IMM, 4, S_TRAP,   NONE,   2'b01, 1);
    // Reset out of TRAP, then fetch timeout
    step("rst_trap", 0, 0, 0, OP_IMM, 4, S_BOOT,   NONE,   2'b00, 0);
    step("boot3",    1, 0, 0, OP_IMM, 4, S_BOOT,   NONE,   2'b00, 0);
    step("to_f0",    1, 0, 0, OP_IMM, 4, S_FETCH,  F_REQ,  2'b00, 0);
    step("to_f1",    1, 0, 0, OP_IMM, 4, S_FETCH,  F_REQ,  2'b00, 0);
    step("to_f2",    1, 0, 0, OP_IMM, 4, S_FETCH,  F_REQ,  2'b00, 0);
    step("to_f3",    1, 0, 0, OP_IMM, 4, S_FETCH,  F_REQ,  2'b00, 0);
    step("to_t0",    1, 1, 0, OP_IMM, 4, S_TRAP,   NONE,   2'b10, 0);
    step("to_t1",    1, 1, 0, OP_IMM, 4, S_TRAP,   NONE,   2'b10, 0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
RV_MULTICYCLE_CTRL -- requirements
Module: rv_multicycle_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255: maximum cycles to wait for mem_ack in FETCH or MEM; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opcode  input  7  decoded instr[6:0] from the instruction register.
REQ-005 SHALL have port rd  input  5  decoded instr[11:7].
REQ-006 SHALL have port branch_taken  input  1  ALU branch comparison result, valid in EXEC.
REQ-007 SHALL have port mem_ack  input  1  memory completion strobe, one cycle.
REQ-008 SHALL have port mem_req  output  1  memory request, held until ack.
REQ-009 SHALL have port mem_we  output  1  store write enable, qualified by mem_req.
REQ-010 SHALL have port mem_addr_sel  output  1  address source: 0 = PC, 1 = ALU.
REQ-011 SHALL have port ir_we  output  1  instruction register load strobe.
REQ-012 SHALL have port pc_we  output  1  PC update strobe.
REQ-013 SHALL have port pc_sel  output  2  PC source: 00 = PC+4, 01 = PC+imm, 10 = ALU&~1.
REQ-014 SHALL have port rf_we  output  1  register file write strobe.
REQ-015 SHALL have port wb_sel  output  2  write-back source: 00 = ALU, 01 = memory, 10 = PC+4, 11 = imm.
REQ-016 SHALL have port state  output  3  current state encoding.
REQ-017 SHALL have port trap  output  1  high while in TRAP.
REQ-018 SHALL have port trap_cause  output  2  01 = illegal opcode, 10 = bus timeout, 00 = none.
REQ-019 SHALL have port instret  output  32  retired-instruction counter.

Function
REQ-020 SHALL encode states as BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7; 6 is unreachable and SHALL go to TRAP with cause 01.
REQ-021 SHALL recognise these legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011; any other opcode is illegal.
REQ-022 BOOT SHALL deassert all strobes for one cycle and then go to FETCH.
REQ-023 FETCH SHALL assert mem_req=1, mem_we=0, mem_addr_sel=0; on the mem_ack cycle it SHALL assert ir_we=1 combinationally and go to DECODE next.
REQ-024 DECODE SHALL register opcode and rd internally; illegal opcode -> TRAP with cause 01; otherwise -> EXEC.
REQ-025 EXEC for BRANCH SHALL assert pc_we=1 with pc_sel=01 if branch_taken and 00 otherwise, then go to FETCH.
REQ-026 EXEC for LOAD or STORE SHALL go to MEM; all other legal opcodes SHALL go to WB; there are no strobes in EXEC except for BRANCH.
REQ-027 MEM SHALL assert mem_req=1, mem_addr_sel=1, and mem_we=1 for STORE only; on ack, STORE -> pc_we=1, pc_sel=00, then FETCH; LOAD -> WB.
REQ-028 WB SHALL assert rf_we=1 only if the registered rd is not 0.
REQ-029 WB SHALL select wb_sel: LUI 11; LOAD 01; JAL/JALR 10; else 00.
REQ-030 WB SHALL assert pc_we=1 with pc_sel: JAL 01; JALR 10; else 00; next state is FETCH.
REQ-031 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-032 Timeout: the wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without ack.
REQ-033 An ack on the TIMEOUT-th cycle SHALL be accepted; no ack by the end of that cycle SHALL cause TRAP with cause 10 and mem_req=0.
REQ-034 instret SHALL increment by 1 (mod 2^32) on every transition into FETCH from EXEC, MEM or WB; there is no increment on trap.
REQ-035 TRAP SHALL be terminal: all strobes 0, trap=1, trap_cause held; exit only by reset.

Reset
REQ-036 rst_n low SHALL immediately force state=BOOT, all strobes 0, trap=0, trap_cause=00, instret=0, wait counter 0 and internal opcode/rd 0, regardless of current state, including mid-MEM.
REQ-037 After rst_n rises, the first rising edge SHALL move to FETCH, so mem_req first rises in the second cycle.

Verification
REQ-038 The bench SHALL cover: ADDI rd=5 with ack on the first FETCH cycle -> BOOT,FETCH,DECODE,EXEC,WB; rf_we=1, wb_sel=00, pc_we=1, pc_sel=00; instret 0->1.
REQ-039 The bench SHALL cover: LOAD rd=3 with data ack 3 cycles late -> mem_req high for 4 MEM cycles with mem_we=0, then WB with wb_sel=01; instret +1.
REQ-040 The bench SHALL cover: BRANCH with branch_taken=1 -> EXEC pc_we=1, pc_sel=01, next FETCH, no rf_we.
REQ-041 The bench SHALL cover: opcode 1111111 -> TRAP, trap=1, trap_cause=01, instret unchanged, mem_req stays 0 thereafter.
REQ-042 The bench SHALL cover: TIMEOUT=4 and no ack in FETCH -> 4 cycles of mem_req then TRAP with cause 10; a second run with ack on cycle 4 -> DECODE.
REQ-043 The bench SHALL cover: JAL rd=0 -> rf_we=0, pc_sel=01; reset asserted mid-MEM of a STORE -> mem_we and mem_req drop to 0 immediately and instret=0.
